// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and scan state encoding for the 7-segment scan driver
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int         DP_BIT    = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg_scan_tick.sv
// rtl/seg_scan_tick.sv - per-digit slot counter with slot start / blank end / slot end strobes
module seg_scan_tick #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic slot_start,
  output logic blank_end,
  output logic slot_end
);

  localparam int CW      = $clog2(SCAN_DIV);
  localparam int BL_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  logic [CW-1:0] cnt_q, cnt_d;

  // blank_end marks the last blank cycle, so the FSM is in ON once cnt reaches BLANK_CYCLES
  always_comb begin
    slot_start = (cnt_q == '0);
    slot_end   = (cnt_q == CW'(SCAN_DIV - 1));
    blank_end  = (BLANK_CYCLES > 0) && (cnt_q == CW'(BL_LAST));
  end

  always_comb begin
    cnt_d = '0;
    if (run) begin
      cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_driver_ca.sv
// rtl/seg_scan_driver_ca.sv - time-multiplexed common-anode 7-segment scan driver
// Blanking between digits, per-digit blink and dp insertion; all outputs registered.
module seg_scan_driver_ca
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS        = 6,
  parameter int SCAN_DIV          = 50000,
  parameter int BLANK_CYCLES      = 500,
  parameter int BLINK_HALF_FRAMES = 100,
  parameter int DIG_ACTIVE_LOW    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [8*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7:0]              dula_out,
  output logic [NUM_DIGITS-1:0]   wela_out,
  output logic                    frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_HALF_FRAMES > 1) ? $clog2(BLINK_HALF_FRAMES) : 1;
  localparam logic [NUM_DIGITS-1:0] WELA_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam scan_state_e SLOT_ENTRY = (BLANK_CYCLES == 0) ? ON : BLANK;

  scan_state_e           state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic                  blink_q, blink_d;
  logic [7:0]            code_q, code_d;
  logic [7:0]            dula_q, dula_d;
  logic [NUM_DIGITS-1:0] wela_q, wela_d;
  logic                  fd_q, fd_d;

  logic                  run, slot_start, blank_end, slot_end, wrap, lit;
  logic [7:0]            sel_code, cur_code;
  logic                  sel_dp, sel_blink;
  logic [NUM_DIGITS-1:0] onehot;

  assign run = (state_q != IDLE) && enable;

  seg_scan_tick #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .slot_start (slot_start),
    .blank_end  (blank_end),
    .slot_end   (slot_end)
  );

  always_comb begin
    sel_code  = SEG_BLANK;
    sel_dp    = 1'b0;
    sel_blink = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_code  = seg_in[8*i +: 8];
        sel_dp    = dp_mask[i];
        sel_blink = blink_mask[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = SLOT_ENTRY;
        BLANK:   if (blank_end) state_d = ON;
        ON:      if (slot_end) state_d = SLOT_ENTRY;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wrap    = run && (state_q == ON) && slot_end && (idx_q == IW'(NUM_DIGITS - 1));
    idx_d   = idx_q;
    frame_d = frame_q;
    blink_d = blink_q;
    if (!run) begin
      idx_d = '0;
    end else if ((state_q == ON) && slot_end) begin
      idx_d = wrap ? '0 : idx_q + IW'(1);
    end
    if (wrap) begin
      if (frame_q == FW'(BLINK_HALF_FRAMES - 1)) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
    // Latching once per slot keeps a mid-slot seg_in change from tearing the digit
    code_d = (run && slot_start) ? sel_code : code_q;
  end

  always_comb begin
    cur_code         = slot_start ? sel_code : code_q;
    cur_code[DP_BIT] = cur_code[DP_BIT] & ~sel_dp;
    onehot           = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    lit              = enable && (state_q == ON) && !(blink_q && sel_blink);
    dula_d           = lit ? cur_code : SEG_BLANK;
    wela_d           = lit ? (WELA_OFF ^ onehot) : WELA_OFF;
    fd_d             = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      frame_q <= '0;
      blink_q <= 1'b0;
      code_q  <= SEG_BLANK;
      dula_q  <= SEG_BLANK;
      wela_q  <= WELA_OFF;
      fd_q    <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
      code_q  <= code_d;
      dula_q  <= dula_d;
      wela_q  <= wela_d;
      fd_q    <= fd_d;
    end
  end

  assign dula_out   = dula_q;
  assign wela_out   = wela_q;
  assign frame_done = fd_q;

endmodule
